vc_plane_scheduler: RTL and testbench
=====================================

VC_PLANE_SCHEDULER -- requirements
Module: vc_plane_scheduler

Interface
REQ-001 SHALL have parameter VC, default 4; number of VC planes, legal range 2..8.
REQ-002 SHALL have parameter CRIT_WEIGHT, default 3; maximum consecutive grants to critical plane 0 per visit, legal range 1..15.
REQ-003 SHALL have parameter LOCK, default 0; 0 means slot mode (one grant per cycle), 1 means packet mode (grant held until tail).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port vcReq  input  VC  bit i high means plane i has a pending flit.
REQ-007 SHALL have port vcTail  input  VC  bit i high means plane i transfers a tail flit this cycle; used only when LOCK=1.
REQ-008 SHALL have port planeSel  output  VC+1  binary index of the active plane, matching the existing VC plane selector bus width.
REQ-009 SHALL have port planeValid  output  1  high when planeSel names a granted plane.
REQ-010 SHALL have port planeGrant  output  VC  one-hot grant; all-zero when planeValid is low.

Function
REQ-011 SHALL register all outputs: the decision made from cycle-N inputs appears on outputs in cycle N+1 (1-cycle latency).
REQ-012 SHALL maintain registers: active (last granted index), credit (4 bits) and a state of IDLE, CRIT or RR.
REQ-013 SHALL behave as follows in state IDLE: planeValid=0, planeGrant=0, planeSel holds the last active index.
REQ-014 SHALL compute the round-robin search order as active+1, active+2, ... modulo VC; the first plane with vcReq high wins.
REQ-015 SHALL, when the winner is plane 0, enter CRIT with credit=CRIT_WEIGHT-1; otherwise enter RR with credit=0.
REQ-016 SHALL, in CRIT and slot mode, keep plane 0 and decrement credit when credit>0 and vcReq[0]=1; otherwise run the REQ-014 search.
REQ-017 SHALL, in RR and slot mode, run the REQ-014 search every cycle.
REQ-018 SHALL, in packet mode, hold the active plane while vcReq[active]=1 and vcTail[active]=0; the REQ-016/REQ-017 rules apply only in the cycle after a tail, and credit counts packets.
REQ-019 SHALL, in packet mode, treat vcReq[active] falling without a tail as packet abort: release the grant and re-arbitrate normally.
REQ-020 SHALL enter IDLE when no vcReq bit is set at a decision point, leaving active and credit unchanged.
REQ-021 SHALL ignore vcTail bits of non-active planes, and vcTail entirely when LOCK=0.
REQ-022 SHALL give every requesting plane a grant within (VC-1)+CRIT_WEIGHT decision points in slot mode (no starvation).
REQ-023 SHALL zero-extend planeSel; its upper bits are always 0.

Reset
REQ-024 SHALL, on a rising edge with rst=1, set planeSel=0, planeValid=0, planeGrant=0, credit=0, state=IDLE and active=VC-1, so that the first search starts at plane 0.
REQ-025 SHALL let rst override any in-progress grant, credit or packet lock; the first grant after rst falls is decided from that cycle's vcReq.

Verification (VC=4, CRIT_WEIGHT=3)
REQ-026 SHALL cover: LOCK=0, vcReq=4'b1111 held -> planeSel sequence 0,0,0,1,2,3,0,0,0,1,... with planeValid=1 throughout.
REQ-027 SHALL cover: LOCK=0, vcReq=4'b0100 only -> planeSel=2 and planeGrant=4'b0100 every cycle.
REQ-028 SHALL cover: vcReq=0 -> planeValid=0 and planeGrant=0; then vcReq=4'b1000 in cycle N -> planeSel=3 and planeValid=1 in cycle N+1.
REQ-029 SHALL cover: LOCK=0, vcReq=4'b1111, vcReq[0] dropped after the 2nd plane-0 slot -> next planeSel=1 (unused credit forfeited).
REQ-030 SHALL cover: LOCK=1, planes 1 and 2 requesting, vcTail[1] on the 3rd plane-1 cycle -> planeSel=1 for 3 cycles, then 2.
REQ-031 SHALL cover: rst pulsed mid-sequence at planeSel=2 with vcReq=4'b1111 -> all outputs 0 for one cycle, then the sequence restarts 0,0,0,1.

Source files
------------

// File: rtl/vc_plane_scheduler.sv
// VC plane scheduler: critical-weighted round-robin over VC planes with a
// registered one-hot grant, in either slot mode or packet-lock mode.
module vc_plane_scheduler #(
  parameter int VC          = 4,
  parameter int CRIT_WEIGHT = 3,
  parameter int LOCK        = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [VC-1:0] vcReq,
  input  logic [VC-1:0] vcTail,
  output logic [VC:0]   planeSel,
  output logic          planeValid,
  output logic [VC-1:0] planeGrant
);

  localparam int AW = (VC > 1) ? $clog2(VC) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CRIT = 2'd1;
  localparam logic [1:0] RR   = 2'd2;
  localparam logic [3:0]    CREDIT_INIT = 4'(CRIT_WEIGHT - 1);
  localparam logic [AW-1:0] LAST_PLANE  = AW'(VC - 1);
  localparam logic [AW:0]   VC_W        = (AW + 1)'(VC);

  logic [AW-1:0] active, nextActive, rrWinner, cand;
  logic [AW:0]   sum;
  logic [3:0]    credit, nextCredit;
  logic [1:0]    state, nextState;
  logic          rrFound, holdPacket, keepCrit;

  // First requesting plane after the active one, wrapping modulo VC.
  always_comb begin
    rrFound  = 1'b0;
    rrWinner = active;
    sum      = '0;
    cand     = '0;
    for (int k = 1; k <= VC; k++) begin
      sum = {1'b0, active} + (AW + 1)'(k);
      if (sum >= VC_W) sum = sum - VC_W;
      cand = sum[AW-1:0];
      if (!rrFound && vcReq[cand]) begin
        rrFound  = 1'b1;
        rrWinner = cand;
      end
    end
  end

  // A locked packet pins the plane; otherwise plane 0 spends its credit
  // before falling back to the round-robin search.
  always_comb begin
    holdPacket = (LOCK != 0) && (state != IDLE) && vcReq[active] && !vcTail[active];
    keepCrit   = (state == CRIT) && (credit != 4'd0) && vcReq[0];
    nextActive = active;
    nextCredit = credit;
    nextState  = state;
    if (holdPacket) begin
      nextState = state;
    end else if (keepCrit) begin
      nextCredit = credit - 4'd1;
    end else if (rrFound) begin
      nextActive = rrWinner;
      if (rrWinner == '0) begin
        nextState  = CRIT;
        nextCredit = CREDIT_INIT;
      end else begin
        nextState  = RR;
        nextCredit = 4'd0;
      end
    end else begin
      nextState = IDLE;
    end
  end

  // planeSel keeps its last value while idle so the bus shows the last grantee.
  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= LAST_PLANE;
      credit     <= 4'd0;
      state      <= IDLE;
      planeSel   <= '0;
      planeValid <= 1'b0;
      planeGrant <= '0;
    end else begin
      active     <= nextActive;
      credit     <= nextCredit;
      state      <= nextState;
      planeValid <= (nextState != IDLE);
      if (nextState != IDLE) begin
        planeSel   <= (VC + 1)'(nextActive);
        planeGrant <= {{(VC-1){1'b0}}, 1'b1} << nextActive;
      end else begin
        planeGrant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Bench for vc_plane_scheduler: one slot-mode and one packet-mode instance
// (VC=4, CRIT_WEIGHT=3) checked against a behavioural model plus directed sequences.
module tb_vc_plane_scheduler;

  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req0 = '0, tail0 = '0, req1 = '0, tail1 = '0;
  logic [4:0] sel0, sel1;
  logic       valid0, valid1;
  logic [3:0] grant0, grant1;

  int compared   = 0;
  int mismatched = 0;

  int         mAct[2], mCred[2], mSt[2];
  logic [4:0] eSel[2];
  logic       eValid[2];
  logic [3:0] eGrant[2];

  always #5 clk = ~clk;

  vc_plane_scheduler #(.VC(4), .CRIT_WEIGHT(CW), .LOCK(0)) dutSlot (
    .clk(clk), .rst(rst), .vcReq(req0), .vcTail(tail0),
    .planeSel(sel0), .planeValid(valid0), .planeGrant(grant0)
  );

  vc_plane_scheduler #(.VC(4), .CRIT_WEIGHT(CW), .LOCK(1)) dutPkt (
    .clk(clk), .rst(rst), .vcReq(req1), .vcTail(tail1),
    .planeSel(sel1), .planeValid(valid1), .planeGrant(grant1)
  );

  function automatic void modelReset();
    for (int u = 0; u < 2; u++) begin
      mAct[u] = 3; mCred[u] = 0; mSt[u] = 0;
      eSel[u] = '0; eValid[u] = 1'b0; eGrant[u] = '0;
    end
  endfunction

  // mSt: 0 idle, 1 plane-0 critical run, 2 ordinary round-robin grant
  function automatic void modelStep(input int u, input logic [3:0] r, input logic [3:0] t, input bit lock);
    int w = -1;
    bit hold = lock && (mSt[u] != 0) && r[2'(mAct[u])] && !t[2'(mAct[u])];
    if (!hold) begin
      if (mSt[u] == 1 && mCred[u] > 0 && r[0]) begin
        mCred[u] = mCred[u] - 1;
      end else begin
        for (int k = 1; k <= 4; k++)
          if (w < 0 && r[2'((mAct[u] + k) % 4)]) w = (mAct[u] + k) % 4;
        if (w < 0) mSt[u] = 0;
        else begin
          mAct[u]  = w;
          mSt[u]   = (w == 0) ? 1 : 2;
          mCred[u] = (w == 0) ? CW - 1 : 0;
        end
      end
    end
    if (mSt[u] != 0) begin
      eSel[u] = 5'(mAct[u]); eValid[u] = 1'b1; eGrant[u] = 4'(1 << mAct[u]);
    end else begin
      eValid[u] = 1'b0; eGrant[u] = '0;
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] r0, input logic [3:0] t0,
                               input logic [3:0] r1, input logic [3:0] t1, input bit doRst);
    req0 = r0; tail0 = t0; req1 = r1; tail1 = t1; rst = doRst;
    @(posedge clk); #1;
    if (doRst) modelReset();
    else begin
      modelStep(0, r0, t0, 1'b0);
      modelStep(1, r1, t1, 1'b1);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
    compared++;
    if ({sel0, valid0, grant0} !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL resetSlot: got sel=%0d v=%0b g=%b, want all zero", sel0, valid0, grant0);
    end
    compared++;
    if ({sel1, valid1, grant1} !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL resetPkt: got sel=%0d v=%0b g=%b, want all zero", sel1, valid1, grant1);
    end
  endtask

  task automatic test_all_request();
    int seq[10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1111, '0, '0, '0, 1'b0);
      compared++;
      if (sel0 !== 5'(seq[i]) || valid0 !== 1'b1 || grant0 !== 4'(1 << seq[i])) begin
        mismatched++;
        $display("[TB] FAIL allReq cyc%0d: got sel=%0d v=%0b g=%b, want sel=%0d v=1", i, sel0, valid0, grant0, seq[i]);
      end
    end
  endtask

  task automatic test_single_plane();
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, '0, '0, '0, 1'b0);
      compared++;
      if (sel0 !== 5'd2 || valid0 !== 1'b1 || grant0 !== 4'b0100) begin
        mismatched++;
        $display("[TB] FAIL single cyc%0d: got sel=%0d v=%0b g=%b, want sel=2 v=1 g=0100", i, sel0, valid0, grant0);
      end
    end
  endtask

  task automatic test_idle_wakeup();
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, '0, '0, 1'b0);
      compared++;
      if (valid0 !== 1'b0 || grant0 !== 4'b0) begin
        mismatched++;
        $display("[TB] FAIL idle cyc%0d: got v=%0b g=%b, want v=0 g=0000", i, valid0, grant0);
      end
    end
    applyStimulus(4'b1000, '0, '0, '0, 1'b0);
    compared++;
    if (sel0 !== 5'd3 || valid0 !== 1'b1 || grant0 !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL wakeup: got sel=%0d v=%0b g=%b, want sel=3 v=1 g=1000", sel0, valid0, grant0);
    end
    applyStimulus('0, '0, '0, '0, 1'b0);
    compared++;
    if (sel0 !== 5'd3 || valid0 !== 1'b0 || grant0 !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL idleHold: got sel=%0d v=%0b g=%b, want sel=3 v=0 g=0000", sel0, valid0, grant0);
    end
  endtask

  task automatic test_crit_forfeit();
    applyStimulus('0, '0, '0, '0, 1'b1);
    applyStimulus(4'b1111, '0, '0, '0, 1'b0);
    applyStimulus(4'b1111, '0, '0, '0, 1'b0);
    applyStimulus(4'b1110, '0, '0, '0, 1'b0);
    compared++;
    if (sel0 !== 5'd1 || valid0 !== 1'b1 || grant0 !== 4'b0010) begin
      mismatched++;
      $display("[TB] FAIL forfeit: got sel=%0d v=%0b g=%b, want sel=1 v=1 g=0010", sel0, valid0, grant0);
    end
  endtask

  task automatic test_packet();
    int seq[4] = '{1, 1, 1, 2};
    logic [3:0] tails[4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0010};
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus('0, '0, 4'b0110, tails[i], 1'b0);
      compared++;
      if (sel1 !== 5'(seq[i]) || valid1 !== 1'b1 || grant1 !== 4'(1 << seq[i])) begin
        mismatched++;
        $display("[TB] FAIL packet cyc%0d: got sel=%0d v=%0b g=%b, want sel=%0d v=1", i, sel1, valid1, grant1, seq[i]);
      end
    end
    applyStimulus('0, '0, 4'b0011, '0, 1'b0);
    compared++;
    if (sel1 !== 5'd0 || valid1 !== 1'b1 || grant1 !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL abort: got sel=%0d v=%0b g=%b, want sel=0 v=1 g=0001", sel1, valid1, grant1);
    end
  endtask

  task automatic test_reset_mid();
    int seq[4] = '{0, 0, 0, 1};
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, '0, '0, '0, 1'b0);
    compared++;
    if (sel0 !== 5'd2) begin
      mismatched++;
      $display("[TB] FAIL preRst: got sel=%0d, want sel=2", sel0);
    end
    applyStimulus(4'b1111, '0, '0, '0, 1'b1);
    compared++;
    if ({sel0, valid0, grant0} !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL midRst: got sel=%0d v=%0b g=%b, want all zero", sel0, valid0, grant0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, '0, '0, '0, 1'b0);
      compared++;
      if (sel0 !== 5'(seq[i]) || valid0 !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL restart cyc%0d: got sel=%0d v=%0b, want sel=%0d v=1", i, sel0, valid0, seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r0, t0, r1, t1;
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r0 = 4'($urandom);
      t0 = 4'($urandom);
      r1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : req1 | 4'($urandom_range(0, 1));
      t1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      applyStimulus(r0, t0, r1, t1, ($urandom_range(0, 60) == 0));
      compared++;
      if ({sel0, valid0, grant0} !== {eSel[0], eValid[0], eGrant[0]}) begin
        mismatched++;
        $display("[TB] FAIL randSlot cyc%0d: got sel=%0d v=%0b g=%b, want sel=%0d v=%0b g=%b",
                 i, sel0, valid0, grant0, eSel[0], eValid[0], eGrant[0]);
      end
      compared++;
      if ({sel1, valid1, grant1} !== {eSel[1], eValid[1], eGrant[1]}) begin
        mismatched++;
        $display("[TB] FAIL randPkt cyc%0d: got sel=%0d v=%0b g=%b, want sel=%0d v=%0b g=%b",
                 i, sel1, valid1, grant1, eSel[1], eValid[1], eGrant[1]);
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_all_request();
    test_single_plane();
    test_idle_wakeup();
    test_crit_forfeit();
    test_packet();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
